// File: rtl/reg_bank_port.sv
// reg_bank_port: initiator-side access sequencer for the register bank.
// Serialises write-back and two-operand fetch requests onto the bank's
// trigger/address/we/oe/data bus and returns the captured operands.
// Every output, the bus drive enable included, comes from a flop, so the
// next-output logic below looks at the next state rather than the current one.
module reg_bank_port #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_req,
    input  logic [AW-1:0] rn_addr,
    input  logic [AW-1:0] rm_addr,
    input  logic          wr_req,
    input  logic [AW-1:0] wd_addr,
    input  logic [DW-1:0] wd_data,
    output logic          busy,
    output logic          op_valid,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic          wr_done,
    output logic          rb_trigger,
    output logic [AW-1:0] rb_address,
    output logic          rb_we,
    output logic          rb_oe,
    inout  wire  [DW-1:0] rb_data
);

    typedef enum logic [3:0] {
        IDLE, W_SETUP, W_STROBE, W_HOLD,
        A_SETUP, A_STROBE, A_CAPT,
        B_SETUP, B_STROBE, B_CAPT, DONE
    } state_t;

    state_t        state, state_nxt;

    // request latched at accept
    logic          rd_pend_q;
    logic [AW-1:0] rn_q, rm_q, wa_q;
    logic [DW-1:0] wd_q;

    // in IDLE the latches are not loaded yet, so the first access after
    // accept takes its address straight from the request inputs
    logic [AW-1:0] rn_eff, rm_eff, wa_eff;

    // next values of the registered outputs
    logic          busy_d, op_valid_d, wr_done_d, trig_d, we_d, oe_d;
    logic [AW-1:0] addr_d;

    logic          bus_en;

    assign rn_eff = (state == IDLE) ? rn_addr : rn_q;
    assign rm_eff = (state == IDLE) ? rm_addr : rm_q;
    assign wa_eff = (state == IDLE) ? wd_addr : wa_q;

    // the bus is driven only during the three write phases
    assign rb_data = bus_en ? wd_q : 'z;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state: write goes first, a pending read follows in the same transaction
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr_req)      state_nxt = W_SETUP;
                else if (rd_req) state_nxt = A_SETUP;
            end
            W_SETUP:  state_nxt = W_STROBE;
            W_STROBE: state_nxt = W_HOLD;
            W_HOLD:   state_nxt = rd_pend_q ? A_SETUP : IDLE;
            A_SETUP:  state_nxt = A_STROBE;
            A_STROBE: state_nxt = A_CAPT;
            A_CAPT:   state_nxt = B_SETUP;
            B_SETUP:  state_nxt = B_STROBE;
            B_STROBE: state_nxt = B_CAPT;
            B_CAPT:   state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // next-output values, decoded from the state being entered
    always_comb begin
        busy_d     = (state_nxt != IDLE);
        op_valid_d = (state_nxt == DONE);
        wr_done_d  = (state == W_HOLD) && !rd_pend_q;
        trig_d     = rb_trigger;
        we_d       = 1'b0;
        oe_d       = 1'b0;
        addr_d     = rb_address;
        case (state_nxt)
            W_SETUP, W_STROBE, W_HOLD: begin
                we_d   = 1'b1;
                addr_d = wa_eff;
            end
            A_SETUP, A_STROBE, A_CAPT: begin
                oe_d   = 1'b1;
                addr_d = rn_eff;
            end
            B_SETUP, B_STROBE, B_CAPT: begin
                oe_d   = 1'b1;
                addr_d = rm_eff;
            end
            default: ;
        endcase
        if (state_nxt == W_STROBE || state_nxt == A_STROBE || state_nxt == B_STROBE)
            trig_d = ~rb_trigger;
    end

    // request latches; reloaded every IDLE cycle, frozen while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rn_q      <= '0;
            rm_q      <= '0;
            wa_q      <= '0;
            wd_q      <= '0;
        end else if (state == IDLE) begin
            rd_pend_q <= rd_req;
            rn_q      <= rn_addr;
            rm_q      <= rm_addr;
            wa_q      <= wd_addr;
            wd_q      <= wd_data;
        end
    end

    // output registers and operand capture at the end of each CAPT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            op_valid   <= 1'b0;
            wr_done    <= 1'b0;
            rb_trigger <= 1'b0;
            rb_address <= '0;
            rb_we      <= 1'b0;
            rb_oe      <= 1'b0;
            bus_en     <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
        end else begin
            busy       <= busy_d;
            op_valid   <= op_valid_d;
            wr_done    <= wr_done_d;
            rb_trigger <= trig_d;
            rb_address <= addr_d;
            rb_we      <= we_d;
            rb_oe      <= oe_d;
            bus_en     <= we_d;
            if (state == A_CAPT) op_a <= rb_data;
            if (state == B_CAPT) op_b <= rb_data;
        end
    end

endmodule
